npu_axis_feeder: RTL and testbench

//  AXI-Stream master that drives the NPU's 8-bit s00_axis slave. Takes a frame descriptor,

---
 rtl/npu_axis_feeder_pkg.sv | 26 ++
 rtl/npu_axis_feeder_skid_fifo.sv | 48 ++++
 rtl/npu_axis_feeder.sv | 183 ++++++++++++++++++
 tb/tb_npu_axis_feeder.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/npu_axis_feeder_pkg.sv
// Shared constants for the NPU input-stream feeder: default widths, tuser field layout
// (common with axi_stream_input) and the 2-bit feeder FSM encoding.
package npu_axis_feeder_pkg;

    localparam int unsigned DefaultAddrWidth        = 13;
    localparam int unsigned DefaultMaxAddrWidth     = 16;
    localparam int unsigned DefaultDataWidth        = 8;
    localparam int unsigned DefaultNumChannelsWidth = 7;

    localparam int unsigned TuserWidth = 4 * DefaultAddrWidth + DefaultNumChannelsWidth;

    // tuser = {num_channels, ker_col, ker_row, img_col, img_row}
    localparam int unsigned TuserImgRowLsb = 0;
    localparam int unsigned TuserImgColLsb = DefaultAddrWidth;
    localparam int unsigned TuserKerRowLsb = 2 * DefaultAddrWidth;
    localparam int unsigned TuserKerColLsb = 3 * DefaultAddrWidth;
    localparam int unsigned TuserNumChLsb  = 4 * DefaultAddrWidth;

    typedef enum logic [1:0] {
        FeedIdle   = 2'd0,
        FeedStream = 2'd1,
        FeedDrain  = 2'd2,
        FeedDone   = 2'd3
    } feed_state_e;

endpackage

// File: rtl/npu_axis_feeder_skid_fifo.sv
// Two-entry FIFO of {tlast, tdata} that absorbs SRAM read data while the stream is stalled.
module npu_axis_feeder_skid_fifo #(
    parameter int unsigned Width = 9
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [Width-1:0] wdata_i,
    output logic [Width-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [1:0]       count_o
);

    logic [Width-1:0] mem_q [2];
    logic             wr_ptr_q;
    logic             rd_ptr_q;
    logic [1:0]       count_q;
    logic             push_ok;
    logic             pop_ok;

    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            if (push_ok) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= ~wr_ptr_q;
            end
            if (pop_ok) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            count_q <= count_q + {1'b0, push_ok} - {1'b0, pop_ok};
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == 2'd2);
    assign empty_o = (count_q == 2'd0);
    assign count_o = count_q;

endmodule

// File: rtl/npu_axis_feeder.sv
// AXI-Stream master feeding the NPU s00_axis slave from a 1-cycle-latency source SRAM.
// Define NPU_FEEDER_STATS_EN to add the stat_beats/stat_stalls counters.
module npu_axis_feeder
    import npu_axis_feeder_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH         = DefaultAddrWidth,
    parameter int unsigned MAX_ADDR_WIDTH     = DefaultMaxAddrWidth,
    parameter int unsigned DATA_WIDTH         = DefaultDataWidth,
    parameter int unsigned NUM_CHANNELS_WIDTH = DefaultNumChannelsWidth
) (
    input  logic                                        m00_axis_aclk,
    input  logic                                        m00_axis_aresetn,
    input  logic                                        cmd_valid,
    output logic                                        cmd_ready,
    input  logic [MAX_ADDR_WIDTH-1:0]                   cmd_base_addr,
    input  logic [MAX_ADDR_WIDTH-1:0]                   cmd_len,
    input  logic [4*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]  cmd_tuser,
    output logic                                        rd_en,
    output logic [MAX_ADDR_WIDTH-1:0]                   rd_addr,
    input  logic [DATA_WIDTH-1:0]                       rd_data,
    output logic [DATA_WIDTH-1:0]                       m00_axis_tdata,
    output logic [DATA_WIDTH/8-1:0]                     m00_axis_tstrb,
    output logic                                        m00_axis_tvalid,
    input  logic                                        m00_axis_tready,
    output logic                                        m00_axis_tlast,
    output logic [4*ADDR_WIDTH+NUM_CHANNELS_WIDTH-1:0]  m00_axis_tuser,
    output logic                                        done
`ifdef NPU_FEEDER_STATS_EN
    ,
    output logic [31:0]                                 stat_beats,
    output logic [31:0]                                 stat_stalls
`endif
);

    localparam int unsigned TuW = 4 * ADDR_WIDTH + NUM_CHANNELS_WIDTH;

    feed_state_e               state_q, state_d;
    logic                      ready_q;
    logic [MAX_ADDR_WIDTH-1:0] base_q, base_d;
    logic [MAX_ADDR_WIDTH-1:0] len_q, len_d;
    logic [MAX_ADDR_WIDTH-1:0] rd_cnt_q, rd_cnt_d;
    logic [TuW-1:0]            tuser_q, tuser_d;
    logic                      inflight_q;
    logic                      inflight_last_q;

    logic                      cmd_fire;
    logic                      rd_last;
    logic                      beat_fire;
    logic [1:0]                occ;
    logic                      fifo_push;
    logic                      fifo_pop;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic [1:0]                fifo_count;
    logic [DATA_WIDTH:0]       fifo_rdata;
    logic [DATA_WIDTH:0]       head;

    assign cmd_ready = ready_q && (state_q == FeedIdle);
    assign cmd_fire  = cmd_valid && cmd_ready;
    assign rd_last   = (rd_cnt_q == len_q - MAX_ADDR_WIDTH'(1));
    assign rd_addr   = base_q + rd_cnt_q;
    assign occ       = fifo_count + {1'b0, inflight_q};

    always_comb begin
        state_d  = state_q;
        base_d   = base_q;
        len_d    = len_q;
        tuser_d  = tuser_q;
        rd_cnt_d = rd_cnt_q;
        rd_en    = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            FeedIdle: begin
                if (cmd_fire) begin
                    base_d   = cmd_base_addr;
                    len_d    = cmd_len;
                    tuser_d  = cmd_tuser;
                    rd_cnt_d = '0;
                    state_d  = (cmd_len == '0) ? FeedDone : FeedStream;
                end
            end
            FeedStream: begin
                // Cap skid entries plus the in-flight read at two so a stall never drops a byte.
                if (occ < 2'd2 && !fifo_full) begin
                    rd_en    = 1'b1;
                    rd_cnt_d = rd_cnt_q + MAX_ADDR_WIDTH'(1);
                    if (rd_last) begin
                        state_d = FeedDrain;
                    end
                end
            end
            FeedDrain: begin
                if (beat_fire && m00_axis_tlast) begin
                    state_d = FeedDone;
                end
            end
            FeedDone: begin
                done    = 1'b1;
                state_d = FeedIdle;
            end
            default: state_d = FeedIdle;
        endcase
    end

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            state_q         <= FeedIdle;
            ready_q         <= 1'b0;
            base_q          <= '0;
            len_q           <= '0;
            rd_cnt_q        <= '0;
            tuser_q         <= '0;
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            ready_q         <= 1'b1;
            base_q          <= base_d;
            len_q           <= len_d;
            rd_cnt_q        <= rd_cnt_d;
            tuser_q         <= tuser_d;
            inflight_q      <= rd_en;
            inflight_last_q <= rd_en && rd_last;
        end
    end

    // The SRAM byte bypasses the FIFO when it is empty and the sink takes it immediately.
    assign fifo_push = inflight_q && !(fifo_empty && m00_axis_tready);
    assign fifo_pop  = !fifo_empty && m00_axis_tready;

    npu_axis_feeder_skid_fifo #(
        .Width (DATA_WIDTH + 1)
    ) u_skid_fifo (
        .clk_i   (m00_axis_aclk),
        .rst_ni  (m00_axis_aresetn),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i ({inflight_last_q, rd_data}),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    always_comb begin
        head = '0;
        if (!fifo_empty) begin
            head = fifo_rdata;
        end else if (inflight_q) begin
            head = {inflight_last_q, rd_data};
        end
    end

    assign m00_axis_tvalid = !fifo_empty || inflight_q;
    assign m00_axis_tdata  = head[DATA_WIDTH-1:0];
    assign m00_axis_tlast  = head[DATA_WIDTH];
    assign m00_axis_tuser  = tuser_q;
    assign m00_axis_tstrb  = '1;
    assign beat_fire       = m00_axis_tvalid && m00_axis_tready;

`ifdef NPU_FEEDER_STATS_EN
    logic [31:0] stat_beats_q;
    logic [31:0] stat_stalls_q;

    always_ff @(posedge m00_axis_aclk) begin
        if (!m00_axis_aresetn) begin
            stat_beats_q  <= '0;
            stat_stalls_q <= '0;
        end else begin
            if (beat_fire && stat_beats_q != 32'hFFFF_FFFF) begin
                stat_beats_q <= stat_beats_q + 32'd1;
            end
            if (m00_axis_tvalid && !m00_axis_tready && stat_stalls_q != 32'hFFFF_FFFF) begin
                stat_stalls_q <= stat_stalls_q + 32'd1;
            end
        end
    end

    assign stat_beats  = stat_beats_q;
    assign stat_stalls = stat_stalls_q;
`endif

endmodule

// File: tb/tb_npu_axis_feeder.sv
// Directed, table-driven bench for npu_axis_feeder with a behavioural 1-cycle source SRAM.
module tb_npu_axis_feeder;

    localparam int TW = 59;

    logic            clk = 1'b0;
    logic            m00_axis_aresetn;
    logic            cmd_valid;
    logic            cmd_ready;
    logic [15:0]     cmd_base_addr;
    logic [15:0]     cmd_len;
    logic [TW-1:0]   cmd_tuser;
    logic            rd_en;
    logic [15:0]     rd_addr;
    logic [7:0]      rd_data;
    logic [7:0]      m00_axis_tdata;
    logic [0:0]      m00_axis_tstrb;
    logic            m00_axis_tvalid;
    logic            m00_axis_tready;
    logic            m00_axis_tlast;
    logic [TW-1:0]   m00_axis_tuser;
    logic            done;
`ifdef NPU_FEEDER_STATS_EN
    logic [31:0]     stat_beats;
    logic [31:0]     stat_stalls;
`endif

    int errors = 0;
    int checks = 0;
    logic [7:0] mem [0:65535];

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rd_en) rd_data <= mem[rd_addr];
    end

    npu_axis_feeder dut (
        .m00_axis_aclk    (clk),
        .m00_axis_aresetn (m00_axis_aresetn),
        .cmd_valid        (cmd_valid),
        .cmd_ready        (cmd_ready),
        .cmd_base_addr    (cmd_base_addr),
        .cmd_len          (cmd_len),
        .cmd_tuser        (cmd_tuser),
        .rd_en            (rd_en),
        .rd_addr          (rd_addr),
        .rd_data          (rd_data),
        .m00_axis_tdata   (m00_axis_tdata),
        .m00_axis_tstrb   (m00_axis_tstrb),
        .m00_axis_tvalid  (m00_axis_tvalid),
        .m00_axis_tready  (m00_axis_tready),
        .m00_axis_tlast   (m00_axis_tlast),
        .m00_axis_tuser   (m00_axis_tuser),
        .done             (done)
`ifdef NPU_FEEDER_STATS_EN
        ,
        .stat_beats       (stat_beats),
        .stat_stalls      (stat_stalls)
`endif
    );

    typedef struct {
        logic        tready;
        logic        rd_en;
        logic [15:0] rd_addr;
        logic        tvalid;
        logic [7:0]  tdata;
        logic        tlast;
        logic        done;
        logic        cmd_ready;
    } vec_t;

    vec_t s1[7];
    vec_t s2[10];
    vec_t s3[2];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, ".cmd_ready"}, cmd_ready, 0);
        check({tag, ".rd_en"}, rd_en, 0);
        check({tag, ".rd_addr"}, rd_addr, 0);
        check({tag, ".tvalid"}, m00_axis_tvalid, 0);
        check({tag, ".tlast"}, m00_axis_tlast, 0);
        check({tag, ".tdata"}, m00_axis_tdata, 0);
        check({tag, ".tuser"}, m00_axis_tuser, 0);
        check({tag, ".done"}, done, 0);
`ifdef NPU_FEEDER_STATS_EN
        check({tag, ".stat_beats"}, stat_beats, 0);
        check({tag, ".stat_stalls"}, stat_stalls, 0);
`endif
    endtask

    task automatic apply_reset(input string tag);
        m00_axis_aresetn = 1'b0;
        cmd_valid        = 1'b0;
        m00_axis_tready  = 1'b1;
        tick();
        tick();
        check_reset_outputs(tag);
        m00_axis_aresetn = 1'b1;
        tick();
        check({tag, ".ready_after_release"}, cmd_ready, 1);
    endtask

    task automatic start_cmd(input logic [15:0] base, input logic [15:0] len,
                             input logic [TW-1:0] tuser, input string tag);
        cmd_base_addr = base;
        cmd_len       = len;
        cmd_tuser     = tuser;
        cmd_valid     = 1'b1;
        #1;
        check({tag, ".cmd_ready"}, cmd_ready, 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic apply_vec(input vec_t v, input string tag);
        m00_axis_tready = v.tready;
        #1;
        check({tag, ".rd_en"}, rd_en, v.rd_en);
        if (v.rd_en) check({tag, ".rd_addr"}, rd_addr, v.rd_addr);
        check({tag, ".tvalid"}, m00_axis_tvalid, v.tvalid);
        if (v.tvalid) begin
            check({tag, ".tdata"}, m00_axis_tdata, v.tdata);
            check({tag, ".tlast"}, m00_axis_tlast, v.tlast);
        end
        check({tag, ".done"}, done, v.done);
        check({tag, ".cmd_ready"}, cmd_ready, v.cmd_ready);
        @(posedge clk);
        #1;
    endtask

    // Streams a whole frame, scoring every accepted beat against mem[] and checking hold on stalls.
    task automatic run_frame(input logic [15:0] base, input logic [15:0] len,
                             input logic [TW-1:0] tuser, input int mode, input string tag);
        int         beats;
        bit         seen_done;
        logic       hold_v;
        logic [7:0] hold_d;
        logic       hold_l;
        beats     = 0;
        seen_done = 1'b0;
        hold_v    = 1'b0;
        hold_d    = 8'h00;
        hold_l    = 1'b0;
        start_cmd(base, len, tuser, tag);
        for (int cyc = 0; cyc < 400 && !seen_done; cyc++) begin
            m00_axis_tready = (mode == 0) ? 1'b1 : (cyc % 3 != 1);
            #1;
            if (hold_v) begin
                check($sformatf("%s.hold_valid%0d", tag, cyc), m00_axis_tvalid, 1);
                check($sformatf("%s.hold_data%0d", tag, cyc), m00_axis_tdata, hold_d);
                check($sformatf("%s.hold_last%0d", tag, cyc), m00_axis_tlast, hold_l);
            end
            if (m00_axis_tvalid && m00_axis_tready) begin
                check($sformatf("%s.data%0d", tag, beats), m00_axis_tdata,
                      mem[16'(base + 16'(beats))]);
                check($sformatf("%s.tuser%0d", tag, beats), m00_axis_tuser, tuser);
                check($sformatf("%s.tlast%0d", tag, beats), m00_axis_tlast,
                      (beats == int'(len) - 1));
                beats++;
            end
            hold_v = m00_axis_tvalid && !m00_axis_tready;
            hold_d = m00_axis_tdata;
            hold_l = m00_axis_tlast;
            if (done) seen_done = 1'b1;
            @(posedge clk);
            #1;
        end
        check({tag, ".beat_count"}, beats, len);
        check({tag, ".done_seen"}, seen_done, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 8'(i * 7 + 1);
        mem[16'h10] = 8'd1;
        mem[16'h11] = 8'd2;
        mem[16'h12] = 8'hFD;
        mem[16'h13] = 8'd4;
        for (int i = 0; i < 75; i++) mem[16'h100 + i] = 8'(i * 5 + 3);
        for (int i = 0; i < 8; i++) mem[16'h200 + i] = 8'(8'h30 + i);

        //          tready rd  addr    tv  data   last done crdy
        s1[0] = '{1'b1, 1'b1, 16'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        s1[1] = '{1'b1, 1'b1, 16'h11, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        s1[2] = '{1'b1, 1'b1, 16'h12, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        s1[3] = '{1'b1, 1'b1, 16'h13, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};
        s1[4] = '{1'b1, 1'b0, 16'h00, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0};
        s1[5] = '{1'b1, 1'b0, 16'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        s1[6] = '{1'b1, 1'b0, 16'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        s2[0] = '{1'b1, 1'b1, 16'h10, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        s2[1] = '{1'b1, 1'b1, 16'h11, 1'b1, 8'h01, 1'b0, 1'b0, 1'b0};
        s2[2] = '{1'b0, 1'b1, 16'h12, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        s2[3] = '{1'b0, 1'b0, 16'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        s2[4] = '{1'b1, 1'b0, 16'h00, 1'b1, 8'h02, 1'b0, 1'b0, 1'b0};
        s2[5] = '{1'b0, 1'b1, 16'h13, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};
        s2[6] = '{1'b1, 1'b0, 16'h00, 1'b1, 8'hFD, 1'b0, 1'b0, 1'b0};
        s2[7] = '{1'b1, 1'b0, 16'h00, 1'b1, 8'h04, 1'b1, 1'b0, 1'b0};
        s2[8] = '{1'b1, 1'b0, 16'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        s2[9] = '{1'b1, 1'b0, 16'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        s3[0] = '{1'b1, 1'b0, 16'h00, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0};
        s3[1] = '{1'b1, 1'b0, 16'h00, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1};

        cmd_valid       = 1'b0;
        cmd_base_addr   = '0;
        cmd_len         = '0;
        cmd_tuser       = '0;
        m00_axis_tready = 1'b1;

        // Back-to-back frame with the sink always ready.
        apply_reset("s1.reset");
        start_cmd(16'h10, 16'd4, 59'h0ABC, "s1");
        for (int i = 0; i < 7; i++) apply_vec(s1[i], $sformatf("s1.c%0d", i + 1));

        // Same frame under the 1,0,0,1,0,1,1 backpressure pattern.
        apply_reset("s2.reset");
        start_cmd(16'h10, 16'd4, 59'h0ABC, "s2");
        for (int i = 0; i < 10; i++) apply_vec(s2[i], $sformatf("s2.c%0d", i + 1));
`ifdef NPU_FEEDER_STATS_EN
        check("s2.stat_beats", stat_beats, 4);
        check("s2.stat_stalls", stat_stalls, 3);
`endif

        // Zero-length frame.
        start_cmd(16'h40, 16'd0, 59'h7, "s3");
        for (int i = 0; i < 2; i++) apply_vec(s3[i], $sformatf("s3.c%0d", i + 1));

        // Long frame with layer metadata and periodic stalls.
        run_frame(16'h100, 16'd75, {7'd3, 13'd3, 13'd3, 13'd5, 13'd5}, 1, "s4");

        // Reset after the second beat of an 8-byte frame, then a fresh 2-byte frame.
        start_cmd(16'h200, 16'd8, 59'h1234, "s5");
        m00_axis_tready = 1'b1;
        tick();
        #1;
        check("s5.beat1_valid", m00_axis_tvalid, 1);
        check("s5.beat1_data", m00_axis_tdata, 8'h30);
        tick();
        #1;
        check("s5.beat2_data", m00_axis_tdata, 8'h31);
        m00_axis_aresetn = 1'b0;
        tick();
        check_reset_outputs("s5.rst");
        tick();
        check("s5.rst_hold_done", done, 0);
        check("s5.rst_hold_valid", m00_axis_tvalid, 0);
        m00_axis_aresetn = 1'b1;
        tick();
        check("s5.ready_after_release", cmd_ready, 1);
        check("s5.no_done", done, 0);
        run_frame(16'h10, 16'd2, 59'h5A5, 1, "s5.new");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
